// File: rtl/booth_seq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : booth_seq_arbiter
//  Purpose  : Two-requester round-robin front end feeding a sequential
//             radix-2 Booth signed multiplier (one step per cycle).
//  Revision : 1.0  initial release
// ============================================================================
module booth_seq_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   input  logic [WIDTH-1:0]   req0_m1,
   input  logic [WIDTH-1:0]   req0_m2,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [WIDTH-1:0]   req1_m1,
   input  logic [WIDTH-1:0]   req1_m2,
   output logic               req1_ready,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res,
   output logic               res_id,
   output logic               busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_rr;
   logic             r_qn;
   logic             r_res_id;
   logic [WIDTH:0]   r_a;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic [CW-1:0]    r_cnt;

   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH:0]   w_mext;
   logic [WIDTH:0]   w_sum;

   // rr names the requester that wins a tie
   assign w_gnt0     = req0_valid & (~req1_valid | ~r_rr);
   assign w_gnt1     = req1_valid & (~req0_valid |  r_rr);
   assign req0_ready = (r_state == S_IDLE) & w_gnt0;
   assign req1_ready = (r_state == S_IDLE) & w_gnt1;
   assign w_accept   = req0_ready | req1_ready;
   assign w_last     = (r_cnt == CW'(1));

   // A is one bit wider than M so that subtracting the most negative M cannot wrap
   assign w_mext = {r_m[WIDTH-1], r_m};

   always_comb begin
      w_sum = r_a;
      case ({r_q[0], r_qn})
         2'b01:   w_sum = r_a + w_mext;
         2'b10:   w_sum = r_a - w_mext;
         default: w_sum = r_a;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)  w_next = S_ITER;
         S_ITER:  if (w_last)    w_next = S_DONE;
         S_DONE:  if (res_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr     <= 1'b0;
         r_qn     <= 1'b0;
         r_res_id <= 1'b0;
         r_a      <= '0;
         r_q      <= '0;
         r_m      <= '0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_rr     <= req0_ready;
         r_res_id <= req1_ready;
         r_m      <= req1_ready ? req1_m1 : req0_m1;
         r_q      <= req1_ready ? req1_m2 : req0_m2;
         r_a      <= '0;
         r_qn     <= 1'b0;
         r_cnt    <= CW'(WIDTH);
      end else if (r_state == S_ITER) begin
         // arithmetic right shift of {A,Q,Qn} after the Booth add/sub
         r_a   <= {w_sum[WIDTH], w_sum[WIDTH:1]};
         r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
         r_qn  <= r_q[0];
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign res       = {r_a[WIDTH-1:0], r_q};
   assign res_id    = r_res_id;
   assign res_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
